// File: rtl/zoom_pkg.sv
// Shared types and constants for the image zoom engine: FSM states, blend mode
// encodings and the largest supported scale exponent.
package zoom_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        EMIT,
        DONE
    } zoom_state_t;

    localparam logic MODE_REPLICATE = 1'b0;
    localparam logic MODE_LINEAR    = 1'b1;
    localparam int   MAX_SCALE_LOG2 = 2;

    // Index of the last sub-pixel step (S-1) for a given scale exponent.
    function automatic logic [1:0] last_step(input logic [1:0] scale_log2);
        return 2'((3'd1 << scale_log2) - 3'd1);
    endfunction

endpackage

// File: rtl/image_zoom_engine_if.sv
// Memory-side bus of the zoom engine: one-shot read request with latent
// response, and a ready-gated write channel.
interface image_zoom_engine_if #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 32
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [PIX_W-1:0]  rd_data;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              wr_ready;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_valid, rd_data, wr_ready
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_valid, rd_data, wr_ready
    );
endinterface

// File: rtl/zoom_interp.sv
// Combinational blend of two neighbouring source pixels for sub-step k of S:
// replicate returns A, linear returns (A*(S-k)+B*k)>>scale_log2 truncated.
module zoom_interp
    import zoom_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic [PIX_W-1:0] a,
    input  logic [PIX_W-1:0] b,
    input  logic [1:0]       k,
    input  logic [1:0]       scale_log2,
    input  logic             mode,
    output logic [PIX_W-1:0] pix
);
    localparam int IW = PIX_W + 3;

    logic [IW-1:0] scale;
    logic [IW-1:0] sum;

    always_comb begin
        scale = IW'(1) << scale_log2;
        sum   = IW'(a) * (scale - IW'(k)) + IW'(b) * IW'(k);
        pix   = (mode == MODE_LINEAR) ? PIX_W'(sum >> scale_log2) : a;
    end
endmodule

// File: rtl/image_zoom_engine.sv
// Integer-factor image upscaler: reads each source row S times, emits S output
// pixels per source column (replicated or horizontally blended) in raster order.
module image_zoom_engine
    import zoom_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 32,
    parameter int DIM_W  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [DIM_W-1:0]  src_width,
    input  logic [DIM_W-1:0]  src_height,
    input  logic [1:0]        scale_log2,
    input  logic              mode,
    image_zoom_engine_if.master mem,
    output logic              busy,
    output logic              done,
    output logic              error
);
    zoom_state_t state, state_next;

    logic [DIM_W-1:0]  cfg_width;
    logic [DIM_W-1:0]  cfg_height;
    logic [1:0]        cfg_scale;
    logic              cfg_mode;
    logic [ADDR_W-1:0] row_start;
    logic [ADDR_W-1:0] wr_ptr;
    logic [DIM_W-1:0]  row;
    logic [DIM_W-1:0]  col;
    logic [1:0]        pass;
    logic [1:0]        step;
    logic              fetch_a;
    logic [PIX_W-1:0]  pix_a;
    logic [PIX_W-1:0]  pix_b;
    logic [PIX_W-1:0]  blend;

    logic              cfg_ok;
    logic [1:0]        step_last;
    logic              col_last;
    logic              next_col_last;
    logic              pass_last;
    logic              row_last;
    logic              wr_fire;
    logic              col_done;
    logic [ADDR_W-1:0] col_off;

    zoom_interp #(.PIX_W(PIX_W)) u_interp (
        .a          (pix_a),
        .b          (pix_b),
        .k          (step),
        .scale_log2 (cfg_scale),
        .mode       (cfg_mode),
        .pix        (blend)
    );

    always_comb begin
        cfg_ok        = (scale_log2 <= 2'(MAX_SCALE_LOG2)) && (src_width != '0) && (src_height != '0);
        step_last     = last_step(cfg_scale);
        col_last      = (col == cfg_width - DIM_W'(1));
        next_col_last = (col + DIM_W'(1) == cfg_width - DIM_W'(1));
        pass_last     = (pass == step_last);
        row_last      = (row == cfg_height - DIM_W'(1));
        wr_fire       = (state == EMIT) && mem.wr_ready;
        col_done      = wr_fire && (step == step_last);
        col_off       = fetch_a ? '0 : ADDR_W'(col) + ADDR_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = cfg_ok ? FETCH : DONE;
            FETCH: state_next = WAIT;
            WAIT: begin
                // After the row's first pixel, a second read is needed only if a right neighbour exists.
                if (mem.rd_valid) state_next = (fetch_a && !col_last) ? FETCH : EMIT;
            end
            EMIT: begin
                if (col_done) begin
                    if (col_last)           state_next = (pass_last && row_last) ? DONE : FETCH;
                    else if (next_col_last) state_next = EMIT;
                    else                    state_next = FETCH;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem.rd_req  = (state == FETCH);
        mem.rd_addr = (state == FETCH) ? row_start + col_off : '0;
        mem.wr_req  = (state == EMIT);
        mem.wr_addr = (state == EMIT) ? wr_ptr : '0;
        mem.wr_data = (state == EMIT) ? blend : '0;
        busy        = (state != IDLE);
        done        = (state == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_width  <= '0;
            cfg_height <= '0;
            cfg_scale  <= '0;
            cfg_mode   <= 1'b0;
            row_start  <= '0;
            wr_ptr     <= '0;
            row        <= '0;
            col        <= '0;
            pass       <= '0;
            step       <= '0;
            fetch_a    <= 1'b0;
            pix_a      <= '0;
            pix_b      <= '0;
            error      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cfg_width  <= src_width;
                        cfg_height <= src_height;
                        cfg_scale  <= scale_log2;
                        cfg_mode   <= mode;
                        row_start  <= src_base;
                        wr_ptr     <= dst_base;
                        row        <= '0;
                        col        <= '0;
                        pass       <= '0;
                        step       <= '0;
                        fetch_a    <= 1'b1;
                        error      <= !cfg_ok;
                    end
                end
                WAIT: begin
                    // Loading B with A as well covers single-column rows with no second read.
                    if (mem.rd_valid) begin
                        pix_b <= mem.rd_data;
                        if (fetch_a) begin
                            pix_a   <= mem.rd_data;
                            fetch_a <= 1'b0;
                        end
                    end
                end
                EMIT: begin
                    if (wr_fire) begin
                        wr_ptr <= wr_ptr + ADDR_W'(1);
                        if (step == step_last) begin
                            step <= '0;
                            if (col_last) begin
                                col     <= '0;
                                fetch_a <= 1'b1;
                                if (pass_last) begin
                                    pass      <= '0;
                                    row       <= row + DIM_W'(1);
                                    row_start <= row_start + ADDR_W'(cfg_width);
                                end else begin
                                    pass <= pass + 2'd1;
                                end
                            end else begin
                                col   <= col + DIM_W'(1);
                                pix_a <= pix_b;
                            end
                        end else begin
                            step <= step + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/image_zoom_engine.md
IMAGE_ZOOM_ENGINE -- requirements
Module: image_zoom_engine

Interface
REQ-001 SHALL have parameter PIX_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, pixel-address width; addresses are pixel indices into data memory.
REQ-003 SHALL have parameter DIM_W, default 10, width of the source width/height fields.
REQ-004 SHALL have ports clk in 1 (system clock) and reset in 1 (asynchronous, active-low: 0 = reset).
REQ-005 SHALL have ports start in 1, pulse to begin a job; src_base in ADDR_W; dst_base in ADDR_W.
REQ-006 SHALL have ports src_width in DIM_W; src_height in DIM_W; scale_log2 in 2 (legal values 0/1/2 give scale S = 1/2/4); mode in 1 (0 replicate, 1 horizontal linear).
REQ-007 SHALL have read ports rd_req out 1; rd_addr out ADDR_W; rd_valid in 1; rd_data in PIX_W.
REQ-008 SHALL have write ports wr_req out 1; wr_addr out ADDR_W; wr_data out PIX_W; wr_ready in 1.
REQ-009 SHALL have status ports busy out 1; done out 1 (one-cycle pulse); error out 1 (held until next start).

Function
REQ-010 SHALL latch all configuration inputs on the cycle start=1 while idle; start while busy SHALL be ignored.
REQ-011 SHALL flag invalid config (scale_log2=3, src_width=0, or src_height=0): error=1 and done pulse on the cycle after start, no memory access.
REQ-012 SHALL use FSM states IDLE, FETCH, WAIT, EMIT, DONE: IDLE->FETCH on valid start; FETCH->WAIT; WAIT->EMIT or FETCH on rd_valid; EMIT->FETCH/EMIT/DONE per counters; DONE->IDLE after one cycle.
REQ-013 SHALL process each source row r exactly S times, once per destination row, re-reading the row from memory on each pass.
REQ-014 SHALL read pixel A=src[r][0] at the start of each destination row, then, before emitting column c, read B=src[r][c+1] when c<W-1, else set B=A.
REQ-015 SHALL hold rd_req high for exactly one cycle with rd_addr valid, keep at most one read outstanding, and capture rd_data on rd_valid with any latency of 1 or more cycles.
REQ-016 SHALL emit S destination pixels per source column, k=0..S-1: mode 0 gives A; mode 1 gives (A*(S-k)+B*k)>>scale_log2, with a PIX_W+3-bit intermediate and truncation.
REQ-017 SHALL hold wr_req, wr_addr and wr_data stable until wr_ready=1; a write is accepted on a cycle where both wr_req and wr_ready are 1.
REQ-018 SHALL write the destination in raster order, starting at dst_base and incrementing by one per accepted write, for W*S*H*S writes in total.
REQ-019 SHALL compute source addresses as src_base + r*W + c from a row-start register plus a column offset, with no multiplier in the address path.
REQ-020 SHALL set A<=B after each column's S-th accepted write.
REQ-021 SHALL assert busy from the cycle after an accepted start through the DONE state; done SHALL pulse in DONE; error SHALL be 0 for valid jobs.
REQ-022 SHALL wrap address arithmetic modulo 2^ADDR_W without flagging it.

Reset
REQ-023 SHALL, while reset=0, force state to IDLE and drive rd_req, wr_req, busy, done, error, rd_addr, wr_addr and wr_data to 0.
REQ-024 SHALL, on reset mid-job, abandon the job; any rd_valid arriving afterwards SHALL be ignored, and no write SHALL issue until a new start.

Structure
REQ-025 SHALL place the state enum, the MODE_REPLICATE/MODE_LINEAR encodings and MAX_SCALE_LOG2=2 in shared package zoom_pkg.
REQ-026 SHALL place the blend arithmetic of REQ-016 in combinational sub-module zoom_interp (inputs A, B, k, scale_log2, mode).

Verification
REQ-027 Source 2x2 [10,20;30,40], S=2, mode 0 -> 16 writes: 10,10,20,20,10,10,20,20,30,30,40,40,30,30,40,40.
REQ-028 Source 1x2 [0,100], S=4, mode 1 -> row 0,25,50,75,100,100,100,100, written 4 times; 32 writes in total.
REQ-029 Source 50x50 ramp, src_base 0, dst_base 8192, S=2, mode 0 -> 10000 writes; last wr_addr 18191; one done pulse; error=0.
REQ-030 scale_log2=3 -> error=1 and done on the next cycle; rd_req and wr_req never asserted.
REQ-031 wr_ready held low for 5 cycles mid-row, random rd_valid latency 1..4 -> output identical to the stall-free run; wr_addr/wr_data stable throughout each stall.
REQ-032 reset=0 asserted during EMIT -> all outputs 0 within the same cycle; a late rd_valid is ignored; a new start gives a correct full job.
